// File: rtl/filter_job_controller.sv
// Filter job controller: sequences one job of pixel words through the filter.
// Optional stall counter is built when FILTER_PERF_COUNT_EN is defined.
module filter_job_controller #(
    parameter int COUNT_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         cfg_mode,
    input  logic [7:0]         cfg_beta,
    input  logic [COUNT_W-1:0] cfg_len,
    output logic               busy,
    output logic               done,
    output logic               err_mode,
    input  logic [31:0]        in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [31:0]        flt_in,
    output logic [1:0]         flt_mode,
    output logic [7:0]         flt_beta,
    input  logic [31:0]        flt_result,
    output logic [31:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        stall_cycles
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state, state_nx;
    logic [1:0]         mode_q;
    logic [7:0]         beta_q;
    logic [COUNT_W-1:0] len_q, issue_cnt, out_cnt;
    logic [31:0]        s1_data;
    logic               s1_valid;
    logic [31:0]        fifo_mem [2];
    logic               wr_ptr, rd_ptr;
    logic [1:0]         fifo_cnt;
    logic               run, fifo_full, pop, adv, load;
    logic               start_ok, start_bad, abort_run, last_pop;

    assign run       = (state == RUN);
    assign fifo_full = (fifo_cnt == 2'd2);
    assign out_valid = run && (fifo_cnt != 2'd0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : 32'd0;
    assign pop       = out_valid && out_ready;
    // S1 moves into the FIFO when there is room, or room appears by a pop
    assign adv       = run && s1_valid && (!fifo_full || pop);
    assign in_ready  = run && (issue_cnt < len_q) && (!s1_valid || adv);
    assign load      = in_valid && in_ready;
    assign flt_in    = s1_valid ? s1_data : 32'd0;
    assign flt_mode  = mode_q;
    assign flt_beta  = beta_q;
    assign start_ok  = (state == IDLE) && start && !cfg_mode[1];
    assign start_bad = (state == IDLE) && start && cfg_mode[1];
    assign abort_run = run && abort;
    assign last_pop  = pop && (out_cnt == len_q - COUNT_W'(1));
    assign busy      = run;
    assign done      = (state == FINISH);

    // Next-state logic; a zero-length job goes straight to the done cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_ok)
                    state_nx = (cfg_len == '0) ? FINISH : RUN;
            end
            RUN: begin
                if (abort)
                    state_nx = IDLE;
                else if (last_pop)
                    state_nx = FINISH;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, job configuration, error flag and word counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= '0;
            beta_q    <= '0;
            len_q     <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            err_mode  <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_bad)
                err_mode <= 1'b1;
            else if (start_ok)
                err_mode <= 1'b0;
            if (start_ok && cfg_len != '0) begin
                mode_q    <= cfg_mode;
                beta_q    <= cfg_beta;
                len_q     <= cfg_len;
                issue_cnt <= '0;
                out_cnt   <= '0;
            end else begin
                if (load)
                    issue_cnt <= issue_cnt + COUNT_W'(1);
                if (pop)
                    out_cnt <= out_cnt + COUNT_W'(1);
            end
        end
    end

    // Input stage and FIFO occupancy; abort flushes everything in flight
    always_ff @(posedge clk) begin
        if (rst || abort_run) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (load) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
            end else if (adv) begin
                s1_valid <= 1'b0;
            end
            if (adv)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, adv} - {1'b0, pop};
        end
    end

    // FIFO storage captures the filter result as S1 advances
    always_ff @(posedge clk) begin
        if (adv)
            fifo_mem[wr_ptr] <= flt_result;
    end

`ifdef FILTER_PERF_COUNT_EN
    logic [31:0] stall_q;

    // Saturating count of cycles where a word waits on downstream
    always_ff @(posedge clk) begin
        if (rst || start_ok)
            stall_q <= '0;
        else if (out_valid && !out_ready && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_filter_job_controller.sv
// Directed self-checking bench for filter_job_controller.
// Filter model: result = input ^ 32'hFF.
module tb_filter_job_controller;
    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_beta;
    logic [19:0] cfg_len;
    logic        busy, done, err_mode;
    logic [31:0] in_data;
    logic        in_valid, in_ready;
    logic [31:0] flt_in, flt_result;
    logic [1:0]  flt_mode;
    logic [7:0]  flt_beta;
    logic [31:0] out_data;
    logic        out_valid, out_ready;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FILTER_PERF_COUNT_EN
    localparam logic [31:0] STALL_EXP = 32'd6;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
`endif

    always #5 clk = ~clk;

    assign flt_result = flt_in ^ 32'hFF;

    filter_job_controller #(.COUNT_W(20)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_mode(cfg_mode), .cfg_beta(cfg_beta), .cfg_len(cfg_len),
        .busy(busy), .done(done), .err_mode(err_mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flt_in(flt_in), .flt_mode(flt_mode), .flt_beta(flt_beta),
        .flt_result(flt_result),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [7:0] b,
                            input logic [19:0] l);
        cfg_mode = m;
        cfg_beta = b;
        cfg_len  = l;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Streams n words base+i; out_ready drops for stall_n cycles
    // beginning stall_at cycles after the first out_valid.
    task automatic run_job(input int n, input logic [31:0] base,
                           input int stall_at, input int stall_n,
                           output int lat, output int blocked);
        int sent, got, dones, cyc, first_acc, first_out;
        bit stalling;
        sent = 0; got = 0; dones = 0; cyc = 0;
        first_acc = -1; first_out = -1; blocked = 0;
        chk("busy_start", {31'd0, busy}, 32'd1);
        while (dones == 0 && cyc < 300) begin
            stalling = (first_out >= 0) && (cyc >= first_out + stall_at) &&
                       (cyc < first_out + stall_at + stall_n);
            in_valid  = (sent < n);
            in_data   = (sent < n) ? base + 32'(sent) : 32'd0;
            out_ready = !stalling;
            #1;
            if (done) begin
                dones++;
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
            if (stalling && in_valid && !in_ready) blocked = 1;
            if (out_valid) begin
                if (first_out < 0) first_out = cyc;
                if (out_ready) begin
                    chk("out_word", out_data, (base + 32'(got)) ^ 32'hFF);
                    got++;
                end
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b1;
        lat = first_out - first_acc;
        chk("words_out", 32'(got), 32'(n));
        chk("done_seen", 32'(dones), 32'd1);
        #1;
        chk("done_once", {31'd0, done}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat, blocked, acc, pops;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_mode = 2'b00; cfg_beta = 8'h00; cfg_len = 20'd0;
        in_data = 32'd0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flt_mode", {30'd0, flt_mode}, 32'd0);
        chk("rst_stall", stall_cycles, 32'd0);
        rst = 1'b0;
        step();

        // Basic job
        do_start(2'b00, 8'h10, 20'd4);
        run_job(4, 32'h0000_1230, 100, 0, lat, blocked);
        chk("basic_latency", 32'(lat), 32'd2);
        cfg_beta = 8'h77;
        cfg_mode = 2'b01;
        #1;
        chk("hold_mode", {30'd0, flt_mode}, 32'd0);
        chk("hold_beta", {24'd0, flt_beta}, 32'h10);

        // Backpressure
        do_start(2'b01, 8'h22, 20'd6);
        run_job(6, 32'h0000_4000, 1, 6, lat, blocked);
        chk("bp_in_ready_drop", 32'(blocked), 32'd1);
        chk("bp_stall_cycles", stall_cycles, STALL_EXP);

        // Reserved mode, then a normal job clears the flag
        do_start(2'b11, 8'h22, 20'd5);
        chk("rsv_err", {31'd0, err_mode}, 32'd1);
        chk("rsv_busy", {31'd0, busy}, 32'd0);
        chk("rsv_in_ready", {31'd0, in_ready}, 32'd0);
        do_start(2'b01, 8'h33, 20'd3);
        chk("rsv_clear", {31'd0, err_mode}, 32'd0);
        run_job(3, 32'h0000_5000, 100, 0, lat, blocked);

        // Zero length
        do_start(2'b01, 8'h44, 20'd0);
        chk("zl_done", {31'd0, done}, 32'd1);
        chk("zl_busy", {31'd0, busy}, 32'd0);
        chk("zl_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("zl_done_end", {31'd0, done}, 32'd0);
        chk("zl_busy_end", {31'd0, busy}, 32'd0);

        // Abort with one word in the FIFO
        do_start(2'b01, 8'h33, 20'd10);
        acc = 0; pops = 0;
        cfg_mode = 2'b11;
        cfg_beta = 8'h55;
        for (int k = 0; k < 3; k++) begin
            in_valid  = 1'b1;
            in_data   = 32'h100 + 32'(k);
            out_ready = 1'b1;
            #1;
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) begin
                chk("ab_word", out_data, 32'h100 ^ 32'hFF);
                pops++;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        abort     = 1'b1;
        #1;
        chk("ab_accepts", 32'(acc), 32'd3);
        chk("ab_pops", 32'(pops), 32'd1);
        chk("ab_fifo_word", {31'd0, out_valid}, 32'd1);
        chk("ab_cfg_mode", {30'd0, flt_mode}, 32'd1);
        chk("ab_cfg_beta", {24'd0, flt_beta}, 32'h33);
        step();
        abort = 1'b0;
        #1;
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ab_done", {31'd0, done}, 32'd0);
        chk("ab_err", {31'd0, err_mode}, 32'd0);
        step();
        chk("ab_done2", {31'd0, done}, 32'd0);
        out_ready = 1'b1;
        do_start(2'b00, 8'h66, 20'd2);
        run_job(2, 32'h0000_0200, 100, 0, lat, blocked);

        // Reset while the FIFO is full
        do_start(2'b10 ^ 2'b11, 8'h99, 20'd8);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h300 + 32'(k);
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("rm_in_blocked", {31'd0, in_ready}, 32'd0);
        rst   = 1'b1;
        start = 1'b1;
        cfg_mode = 2'b01;
        cfg_len  = 20'd3;
        step();
        chk("rm_busy", {31'd0, busy}, 32'd0);
        chk("rm_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rm_out_data", out_data, 32'd0);
        chk("rm_flt_in", flt_in, 32'd0);
        chk("rm_flt_mode", {30'd0, flt_mode}, 32'd0);
        chk("rm_flt_beta", {24'd0, flt_beta}, 32'd0);
        chk("rm_stall", stall_cycles, 32'd0);
        step();
        chk("rm_start_ign", {31'd0, busy}, 32'd0);
        chk("rm_done", {31'd0, done}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        step();
        chk("rm_idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
